mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline memory-access (MEM) stage. Sits between the execute stage and write-back.
- Accepts one decoded memory/ALU op per cycle from EX and drives the 16-bit byte-addressed data memory port: combinational little-endian word read, 2-byte write on the clock edge.
- Handles byte loads/stores via read-merge-write, adds optional wait states, and registers the result into the MEM/WB pipeline register.

Parameters:
- WAIT_CYC, 0, extra cycles each load/store holds the memory port before completing (0 = single-cycle access).
- OP_W, 3, width of op encoding.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a valid op
- in_ready  out  1  stage accepts the op this cycle
- in_op  in  3  0 NONE, 1 LW, 2 LB (sign-ext), 3 LBU, 4 SW, 5 SB; 6/7 treated as NONE
- in_addr  in  16  byte address for loads/stores
- in_wdata  in  16  store data (SB uses [7:0])
- in_alu  in  16  pass-through result for NONE ops
- in_rd  in  3  destination register
- in_rd_we  in  1  op writes a register
- flush  in  1  kill op in WAIT state and block acceptance this cycle
- mem_addr  out  16  memory address (combinational)
- mem_wdata  out  16  memory write data (combinational)
- mem_we  out  1  memory write enable (combinational)
- mem_rdata  in  16  memory read data, {mem[a+1],mem[a]}
- wb_valid  out  1  MEM/WB register valid
- wb_rd  out  3  destination register
- wb_we  out  1  register write enable (0 on error or store)
- wb_data  out  16  load result or pass-through
- wb_err  out  1  access fault on this instruction

Behaviour:
- Reset (async, rst_n=0): state IDLE, wait counter 0, wb_valid=0, wb_rd=0, wb_we=0, wb_data=0, wb_err=0. mem_we=0 while rst_n=0.
- States:
  - IDLE: in_ready=1 unless flush=1.
  - WAIT: in_ready=0; counter counts down from WAIT_CYC.
- Accept: in_valid && in_ready.
  - If the accepted op is a load/store and WAIT_CYC>0: latch the op into a hold register, go to WAIT, counter=WAIT_CYC, mem_we=0 this cycle.
  - Otherwise complete in the same cycle.
- WAIT: the port is driven from the hold register. Completion happens in the cycle where counter==1 (decrement each cycle). Then return to IDLE; in_ready rises the next cycle.
- Completion cycle (single edge):
  - mem_addr=addr. Word ops use addr directly. Byte ops use the word at addr, i.e. byte mem[addr] in the low lane.
  - LW: wb_data=mem_rdata.
  - LB: wb_data={{8{mem_rdata[7]}},mem_rdata[7:0]}.
  - LBU: wb_data={8'h00,mem_rdata[7:0]}.
  - SW: mem_wdata=wdata, mem_we=1.
  - SB: mem_wdata={mem_rdata[15:8],wdata[7:0]}, mem_we=1 (merge preserves byte addr+1).
  - NONE: no port activity; mem_addr=0, mem_we=0; wb_data=in_alu.
  - Stores: wb_we=0. Loads/NONE: wb_we=rd_we.
- Fault: any load/store with addr==16'hFFFF (addr+1 overflows).
  - mem_we forced 0, wb_data=0, wb_we=0, wb_err=1; wb_valid still 1.
- MEM/WB register updates every cycle:
  - wb_valid=1 only on a completion edge.
  - Otherwise wb_valid=0, wb_we=0, wb_err=0, and wb_data/wb_rd hold.
- flush: in WAIT it drops the held op (no write, no wb_valid) and returns to IDLE. flush in the completion cycle wins, so the store is suppressed. flush in IDLE rejects the input.
- Mid-operation reset aborts WAIT immediately with no write.
- Latency: result visible on wb_* one edge after completion. Throughput: 1/cycle at WAIT_CYC=0, 1 per (WAIT_CYC+1) otherwise.

Decomposition:
- Shared package mem_pkg: op encodings (OP_NONE..OP_SB), FAULT_ADDR=16'hFFFF, state enum {IDLE,WAIT}.
- One sub-module: mem_lane_merge. Combinational; given op, addr-word rdata and wdata, produces mem_wdata and the load result (sign/zero extension).

Test Plan:
- WAIT_CYC=0, SW addr 0x0100 data 0xBEEF, then LW 0x0100 -> mem bytes EF,BE; wb_data=0xBEEF one edge after LW, wb_we=1.
- Word 0x1234 at 0x0200; SB addr 0x0200 data 0x00AB, then LW 0x0200 -> 0x12AB. LB 0x0201 -> 0x0012. Byte 0x80 then LB -> 0xFF80, LBU -> 0x0080.
- WAIT_CYC=2, back-to-back LW valid -> in_ready low 2 cycles; each wb_valid spaced 3 cycles; mem_we never pulses for loads.
- SW addr 0xFFFF -> mem_we stays 0, wb_valid=1, wb_err=1, wb_we=0. NONE with in_alu=0x5555 -> wb_data=0x5555, wb_err=0.
- WAIT_CYC=2, SW then flush in 2nd cycle -> no write, no wb_valid, in_ready high next cycle. Repeat with rst_n low mid-WAIT -> all wb_* 0, no write.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: op encodings, fault
// address, FSM state codes and small op-classification helpers.
package mem_pkg;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_LB   = 3'd2;
    localparam logic [2:0] OP_LBU  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_SB   = 3'd5;

    // A word access here would need byte addr+1, which wraps.
    localparam logic [15:0] FAULT_ADDR = 16'hFFFF;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Encodings 6/7 are reserved and behave as NONE.
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: norm_op = op;
            default:                            norm_op = OP_NONE;
        endcase
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        is_load = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        is_store = (op == OP_SW) || (op == OP_SB);
    endfunction

    function automatic logic is_mem(input logic [2:0] op);
        is_mem = is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane handling for the data port: builds the store word (with
// read-merge for byte stores) and the extended load result.
module mem_lane_merge
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [15:0] rdata,
    input  logic [15:0] wdata,
    output logic [15:0] mem_wdata,
    output logic [15:0] load_data
);

    // Select store data and load extension per op; byte ops use the low lane.
    always_comb begin
        mem_wdata = 16'h0000;
        load_data = 16'h0000;
        case (op)
            OP_LW:   load_data = rdata;
            OP_LB:   load_data = {{8{rdata[7]}}, rdata[7:0]};
            OP_LBU:  load_data = {8'h00, rdata[7:0]};
            OP_SW:   mem_wdata = wdata;
            OP_SB:   mem_wdata = {rdata[15:8], wdata[7:0]};
            default: begin
                mem_wdata = 16'h0000;
                load_data = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the byte-addressed data port, optionally holds
// loads/stores for WAIT_CYC extra cycles, and registers results into MEM/WB.
module mem_stage
    import mem_pkg::*;
#(
    parameter int WAIT_CYC = 0,
    parameter int OP_W     = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [15:0]     in_addr,
    input  logic [15:0]     in_wdata,
    input  logic [15:0]     in_alu,
    input  logic [2:0]      in_rd,
    input  logic            in_rd_we,
    input  logic            flush,
    output logic [15:0]     mem_addr,
    output logic [15:0]     mem_wdata,
    output logic            mem_we,
    input  logic [15:0]     mem_rdata,
    output logic            wb_valid,
    output logic [2:0]      wb_rd,
    output logic            wb_we,
    output logic [15:0]     wb_data,
    output logic            wb_err
);

    localparam int              CNT_W    = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic             HAS_WAIT = (WAIT_CYC > 0);

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       h_op_r;
    logic [15:0]      h_addr_r;
    logic [15:0]      h_wdata_r;
    logic [2:0]       h_rd_r;
    logic             h_rd_we_r;

    logic [2:0]  in_op_s;
    logic        acc_s;
    logic        go_wait_s;
    logic        done_s;
    logic [2:0]  act_op_s;
    logic [15:0] act_addr_s;
    logic [15:0] act_wdata_s;
    logic [2:0]  act_rd_s;
    logic        act_rd_we_s;
    logic        fault_s;
    logic [15:0] merge_wdata_s;
    logic [15:0] load_data_s;
    logic [15:0] wb_data_s;
    logic        wb_we_s;

    assign in_op_s  = norm_op(3'(in_op));
    assign in_ready = (state_r == ST_IDLE) && !flush;
    assign acc_s    = in_valid && in_ready;

    // Pick the op driving the port (live input in IDLE, hold register in WAIT) and detect completion.
    always_comb begin
        act_op_s    = OP_NONE;
        act_addr_s  = in_addr;
        act_wdata_s = in_wdata;
        act_rd_s    = in_rd;
        act_rd_we_s = in_rd_we;
        go_wait_s   = 1'b0;
        done_s      = 1'b0;
        if (state_r == ST_WAIT) begin
            act_op_s    = h_op_r;
            act_addr_s  = h_addr_r;
            act_wdata_s = h_wdata_r;
            act_rd_s    = h_rd_r;
            act_rd_we_s = h_rd_we_r;
            done_s      = (cnt_r == CNT_ONE) && !flush;
        end else begin
            act_op_s  = acc_s ? in_op_s : OP_NONE;
            go_wait_s = acc_s && is_mem(in_op_s) && HAS_WAIT;
            done_s    = acc_s && !go_wait_s;
        end
    end

    assign fault_s = is_mem(act_op_s) && (act_addr_s == FAULT_ADDR);

    mem_lane_merge u_merge (
        .op        (act_op_s),
        .rdata     (mem_rdata),
        .wdata     (act_wdata_s),
        .mem_wdata (merge_wdata_s),
        .load_data (load_data_s)
    );

    // Drive the data port; writes only on a fault-free completing store, never in reset.
    always_comb begin
        mem_wdata = merge_wdata_s;
        mem_we    = rst_n && done_s && is_store(act_op_s) && !fault_s;
        if (is_mem(act_op_s)) begin
            mem_addr = act_addr_s;
        end else begin
            mem_addr = 16'h0000;
        end
    end

    // Form the write-back value and register write enable for the completing op.
    always_comb begin
        wb_data_s = 16'h0000;
        wb_we_s   = 1'b0;
        if (fault_s) begin
            wb_data_s = 16'h0000;
            wb_we_s   = 1'b0;
        end else if (is_load(act_op_s)) begin
            wb_data_s = load_data_s;
            wb_we_s   = act_rd_we_s;
        end else if (is_store(act_op_s)) begin
            wb_data_s = 16'h0000;
            wb_we_s   = 1'b0;
        end else begin
            wb_data_s = in_alu;
            wb_we_s   = act_rd_we_s;
        end
    end

    // FSM, wait counter and hold register for multi-cycle accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            h_op_r    <= OP_NONE;
            h_addr_r  <= 16'h0000;
            h_wdata_r <= 16'h0000;
            h_rd_r    <= 3'd0;
            h_rd_we_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_wait_s) begin
                        state_r   <= ST_WAIT;
                        cnt_r     <= CNT_INIT;
                        h_op_r    <= in_op_s;
                        h_addr_r  <= in_addr;
                        h_wdata_r <= in_wdata;
                        h_rd_r    <= in_rd;
                        h_rd_we_r <= in_rd_we;
                    end
                end
                ST_WAIT: begin
                    if (flush || (cnt_r == CNT_ONE)) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // MEM/WB register: loads on completion, otherwise clears the strobes and holds data/rd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= 3'd0;
            wb_we    <= 1'b0;
            wb_data  <= 16'h0000;
            wb_err   <= 1'b0;
        end else if (done_s) begin
            wb_valid <= 1'b1;
            wb_rd    <= act_rd_s;
            wb_we    <= wb_we_s;
            wb_data  <= wb_data_s;
            wb_err   <= fault_s;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a single-cycle instance driven from a vector
// table and a two-wait-state instance driven by hand-written sequences.
module tb_mem_stage;

    localparam logic [2:0] NONE = 3'd0, LW = 3'd1, LB = 3'd2, LBU = 3'd3, SW = 3'd4, SB = 3'd5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- instance A: WAIT_CYC = 0 ----------------
    logic        a_valid, a_ready, a_flush, a_rd_we, a_mwe, a_wbv, a_wbwe, a_err;
    logic [2:0]  a_op, a_rd, a_wbrd;
    logic [15:0] a_addr, a_wdata, a_alu, a_maddr, a_mwdata, a_mrdata, a_wbdata, a_a1;
    logic [7:0]  mem0 [0:65535];

    mem_stage #(.WAIT_CYC(0), .OP_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_op(a_op), .in_addr(a_addr), .in_wdata(a_wdata), .in_alu(a_alu),
        .in_rd(a_rd), .in_rd_we(a_rd_we), .flush(a_flush),
        .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_we(a_mwe), .mem_rdata(a_mrdata),
        .wb_valid(a_wbv), .wb_rd(a_wbrd), .wb_we(a_wbwe), .wb_data(a_wbdata), .wb_err(a_err)
    );

    assign a_a1     = a_maddr + 16'd1;
    assign a_mrdata = {mem0[a_a1], mem0[a_maddr]};
    always @(posedge clk) begin
        if (a_mwe) begin
            mem0[a_maddr] <= a_mwdata[7:0];
            mem0[a_a1]    <= a_mwdata[15:8];
        end
    end

    // ---------------- instance B: WAIT_CYC = 2 ----------------
    logic        b_valid, b_ready, b_flush, b_rd_we, b_mwe, b_wbv, b_wbwe, b_err;
    logic [2:0]  b_op, b_rd, b_wbrd;
    logic [15:0] b_addr, b_wdata, b_alu, b_maddr, b_mwdata, b_mrdata, b_wbdata, b_a1;
    logic [7:0]  mem1 [0:65535];
    int          wr_cnt1 = 0;

    mem_stage #(.WAIT_CYC(2), .OP_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_op(b_op), .in_addr(b_addr), .in_wdata(b_wdata), .in_alu(b_alu),
        .in_rd(b_rd), .in_rd_we(b_rd_we), .flush(b_flush),
        .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_we(b_mwe), .mem_rdata(b_mrdata),
        .wb_valid(b_wbv), .wb_rd(b_wbrd), .wb_we(b_wbwe), .wb_data(b_wbdata), .wb_err(b_err)
    );

    assign b_a1     = b_maddr + 16'd1;
    assign b_mrdata = {mem1[b_a1], mem1[b_maddr]};
    always @(posedge clk) begin
        if (b_mwe) begin
            mem1[b_maddr] <= b_mwdata[7:0];
            mem1[b_a1]    <= b_mwdata[15:8];
            wr_cnt1       <= wr_cnt1 + 1;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic        flush;
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] alu;
        logic [2:0]  rd;
        logic        rd_we;
        logic        e_rdy;
        logic        e_mwe;
        logic        e_wbv;
        logic        e_wbwe;
        logic        e_err;
        logic        chkd;
        logic [15:0] e_data;
        logic [2:0]  e_rd;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input logic v, input logic f, input logic [2:0] op,
                                input logic [15:0] addr, input logic [15:0] wd, input logic [15:0] alu,
                                input logic [2:0] rd, input logic rwe,
                                input logic rdy, input logic mwe, input logic wbv, input logic wbwe,
                                input logic err, input logic chkd, input logic [15:0] d, input logic [2:0] erd);
        vec_t r;
        r.valid = v;   r.flush = f;   r.op = op;     r.addr = addr;
        r.wdata = wd;  r.alu = alu;   r.rd = rd;     r.rd_we = rwe;
        r.e_rdy = rdy; r.e_mwe = mwe; r.e_wbv = wbv; r.e_wbwe = wbwe;
        r.e_err = err; r.chkd = chkd; r.e_data = d;  r.e_rd = erd;
        return r;
    endfunction

    task automatic drive1(input logic v, input logic f, input logic [2:0] op,
                          input logic [15:0] addr, input logic [15:0] wd, input logic [2:0] rd);
        @(negedge clk);
        b_valid = v; b_flush = f; b_op = op; b_addr = addr; b_wdata = wd;
        b_rd = rd; b_rd_we = 1'b1; b_alu = 16'h0000;
        #1;
    endtask

    logic [6:0] exp_rdy;
    logic [6:0] exp_wbv;

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_flush = 1'b0; a_op = NONE; a_addr = 16'h0000; a_wdata = 16'h0000;
        a_alu = 16'h0000; a_rd = 3'd0; a_rd_we = 1'b0;
        b_valid = 1'b0; b_flush = 1'b0; b_op = NONE; b_addr = 16'h0000; b_wdata = 16'h0000;
        b_alu = 16'h0000; b_rd = 3'd0; b_rd_we = 1'b0;

        //                  v  f  op    addr      wdata     alu       rd  rwe rdy mwe wbv wbwe err chkd data     erd
        vt[0]  = mk(1'b1, 1'b0, SW,   16'h0100, 16'hBEEF, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd1);
        vt[1]  = mk(1'b1, 1'b0, LW,   16'h0100, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 3'd2);
        vt[2]  = mk(1'b1, 1'b0, SW,   16'h0200, 16'h1234, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0);
        vt[3]  = mk(1'b1, 1'b0, SB,   16'h0200, 16'h00AB, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0);
        vt[4]  = mk(1'b1, 1'b0, LW,   16'h0200, 16'h0000, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h12AB, 3'd3);
        vt[5]  = mk(1'b1, 1'b0, LB,   16'h0201, 16'h0000, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0012, 3'd4);
        vt[6]  = mk(1'b1, 1'b0, SB,   16'h0300, 16'h0080, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0);
        vt[7]  = mk(1'b1, 1'b0, LB,   16'h0300, 16'h0000, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFF80, 3'd5);
        vt[8]  = mk(1'b1, 1'b0, LBU,  16'h0300, 16'h0000, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0080, 3'd6);
        vt[9]  = mk(1'b1, 1'b0, SW,   16'hFFFF, 16'h1111, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 3'd1);
        vt[10] = mk(1'b1, 1'b0, NONE, 16'h0000, 16'h0000, 16'h5555, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5555, 3'd7);
        vt[11] = mk(1'b1, 1'b0, 3'd7, 16'h0100, 16'h0000, 16'h0A0A, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0A0A, 3'd1);
        vt[12] = mk(1'b1, 1'b0, LW,   16'hFFFF, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 3'd2);
        vt[13] = mk(1'b1, 1'b0, LBU,  16'h0101, 16'h0000, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00BE, 3'd3);
        vt[14] = mk(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00BE, 3'd3);
        vt[15] = mk(1'b1, 1'b1, LW,   16'h0100, 16'h0000, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00BE, 3'd3);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst a_wbv",  {15'd0, a_wbv},  16'h0000);
        chk("rst a_wbrd", {13'd0, a_wbrd}, 16'h0000);
        chk("rst a_wbwe", {15'd0, a_wbwe}, 16'h0000);
        chk("rst a_data", a_wbdata,        16'h0000);
        chk("rst a_err",  {15'd0, a_err},  16'h0000);
        chk("rst b_wbv",  {15'd0, b_wbv},  16'h0000);
        chk("rst b_mwe",  {15'd0, b_mwe},  16'h0000);
        rst_n = 1'b1;

        // Single-cycle instance: table-driven
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_valid = vt[i].valid; a_flush = vt[i].flush; a_op = vt[i].op;
            a_addr = vt[i].addr; a_wdata = vt[i].wdata; a_alu = vt[i].alu;
            a_rd = vt[i].rd; a_rd_we = vt[i].rd_we;
            #1;
            chk($sformatf("v%0d in_ready", i), {15'd0, a_ready}, {15'd0, vt[i].e_rdy});
            chk($sformatf("v%0d mem_we", i),   {15'd0, a_mwe},   {15'd0, vt[i].e_mwe});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wb_valid", i), {15'd0, a_wbv},  {15'd0, vt[i].e_wbv});
            chk($sformatf("v%0d wb_we", i),    {15'd0, a_wbwe}, {15'd0, vt[i].e_wbwe});
            chk($sformatf("v%0d wb_err", i),   {15'd0, a_err},  {15'd0, vt[i].e_err});
            chk($sformatf("v%0d wb_rd", i),    {13'd0, a_wbrd}, {13'd0, vt[i].e_rd});
            if (vt[i].chkd) begin
                chk($sformatf("v%0d wb_data", i), a_wbdata, vt[i].e_data);
            end
        end
        @(negedge clk);
        a_valid = 1'b0; a_flush = 1'b0;
        chk("mem0[0100]", {8'h00, mem0[16'h0100]}, 16'h00EF);
        chk("mem0[0101]", {8'h00, mem0[16'h0101]}, 16'h00BE);
        chk("mem0[0201]", {8'h00, mem0[16'h0201]}, 16'h0012);

        // Wait-state instance: store takes three cycles
        drive1(1'b1, 1'b0, SW, 16'h0400, 16'hCAFE, 3'd5);
        chk("A c0 in_ready", {15'd0, b_ready}, 16'h0001);
        chk("A c0 mem_we",   {15'd0, b_mwe},   16'h0000);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("A c1 in_ready", {15'd0, b_ready}, 16'h0000);
        chk("A c1 mem_we",   {15'd0, b_mwe},   16'h0000);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("A c2 in_ready", {15'd0, b_ready}, 16'h0000);
        chk("A c2 mem_we",   {15'd0, b_mwe},   16'h0001);
        chk("A c2 wb_valid", {15'd0, b_wbv},   16'h0000);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("A c3 in_ready", {15'd0, b_ready}, 16'h0001);
        chk("A c3 wb_valid", {15'd0, b_wbv},   16'h0001);
        chk("A c3 wb_we",    {15'd0, b_wbwe},  16'h0000);
        chk("A mem1[0400]", {8'h00, mem1[16'h0400]}, 16'h00FE);
        chk("A mem1[0401]", {8'h00, mem1[16'h0401]}, 16'h00CA);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);

        // Back-to-back loads with valid held high
        exp_rdy = 7'b1001001;
        exp_wbv = 7'b1001000;
        for (int c = 0; c < 7; c++) begin
            drive1((c < 6) ? 1'b1 : 1'b0, 1'b0, LW, 16'h0400, 16'h0000, 3'd5);
            chk($sformatf("B c%0d in_ready", c), {15'd0, b_ready}, {15'd0, exp_rdy[c]});
            chk($sformatf("B c%0d mem_we", c),   {15'd0, b_mwe},   16'h0000);
            chk($sformatf("B c%0d wb_valid", c), {15'd0, b_wbv},   {15'd0, exp_wbv[c]});
            if (exp_wbv[c]) begin
                chk($sformatf("B c%0d wb_data", c), b_wbdata, 16'hCAFE);
                chk($sformatf("B c%0d wb_we", c),   {15'd0, b_wbwe}, 16'h0001);
            end
        end

        // Flush while waiting drops the store
        drive1(1'b1, 1'b0, SW, 16'h0500, 16'h1357, 3'd1);
        drive1(1'b0, 1'b1, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("C c1 in_ready", {15'd0, b_ready}, 16'h0000);
        chk("C c1 mem_we",   {15'd0, b_mwe},   16'h0000);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("C c2 in_ready", {15'd0, b_ready}, 16'h0001);
        chk("C c2 wb_valid", {15'd0, b_wbv},   16'h0000);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("C c3 wb_valid", {15'd0, b_wbv},   16'h0000);
        chk("C write count", 16'(wr_cnt1),     16'h0001);

        // Flush in the completion cycle suppresses the store
        drive1(1'b1, 1'b0, SW, 16'h0510, 16'h2468, 3'd1);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        drive1(1'b0, 1'b1, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("D c2 mem_we",   {15'd0, b_mwe},   16'h0000);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("D c3 in_ready", {15'd0, b_ready}, 16'h0001);
        chk("D c3 wb_valid", {15'd0, b_wbv},   16'h0000);
        chk("D c3 wb_data",  b_wbdata,         16'hCAFE);
        chk("D write count", 16'(wr_cnt1),     16'h0001);

        // Reset in the middle of a wait aborts the store
        drive1(1'b1, 1'b0, SW, 16'h0600, 16'h9999, 3'd2);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        rst_n = 1'b0;
        #1;
        chk("E wb_valid", {15'd0, b_wbv},  16'h0000);
        chk("E wb_rd",    {13'd0, b_wbrd}, 16'h0000);
        chk("E wb_we",    {15'd0, b_wbwe}, 16'h0000);
        chk("E wb_data",  b_wbdata,        16'h0000);
        chk("E wb_err",   {15'd0, b_err},  16'h0000);
        chk("E mem_we",   {15'd0, b_mwe},  16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("E in_ready", {15'd0, b_ready}, 16'h0001);
        chk("E wb_valid after", {15'd0, b_wbv}, 16'h0000);
        drive1(1'b0, 1'b0, NONE, 16'h0000, 16'h0000, 3'd0);
        chk("E write count", 16'(wr_cnt1), 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
